mips_single_cycle: RTL and testbench



---
 rtl/mips_single_cycle.sv | 357 +++++++++++++++++++++++++++++++++++
 tb/tb_mips_single_cycle.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_single_cycle.sv
// ---------------------------------------------------------------------------
// mips_single_cycle
//   Single-cycle 32-bit MIPS subset core. Fetch, decode, execute, memory
//   access and write-back all complete within one clock period. Instruction
//   memory, register file, ALU and data memory are internal; architectural
//   state is observed through the fixed instance names registradores
//   (registers[0:31]) and data_memory (memory[0:255]).
//
//   Supported: add, sub, and, or, slt, addi, lw, sw, beq, j.
//   Any other opcode or R-type funct behaves as a NOP (PC+4, no writes).
//
// Ports
//   clk    in  1  single clock, all state updates on the rising edge
//   reset  in  1  synchronous active-high; loads PC=0 and clears the
//                 register file and data memory, with no write that cycle
//
// Parameters
//   IMEM_FILE   instruction image name; the 256-word instruction memory
//               is loaded externally
//   DMEM_WORDS  data-memory depth in 32-bit words
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// mips_control
//   Main decoder: opcode -> datapath control.
//   Ports: opcode in; reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
//          mem_write, branch, jump, alu_op[1:0] out.
// ---------------------------------------------------------------------------
module mips_control (
    input  logic [5:0] opcode,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       branch,
    output logic       jump,
    output logic [1:0] alu_op
);
    always_comb begin
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op     = 2'b00;
        case (opcode)
            6'h00: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            6'h08: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            6'h23: begin
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                mem_read   = 1'b1;
            end
            6'h2B: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            6'h04: begin
                branch = 1'b1;
                alu_op = 2'b01;
            end
            6'h02: begin
                jump = 1'b1;
            end
            default: ;  // unknown opcode: every control low, i.e. NOP
        endcase
    end
endmodule

// ---------------------------------------------------------------------------
// mips_alu_control
//   Maps alu_op/funct to the 4-bit ALU operation.
//   Ports: alu_op[1:0], funct[5:0] in; alu_ctrl[3:0] out;
//          funct_valid out (high when the R-type funct is one we implement).
// ---------------------------------------------------------------------------
module mips_alu_control (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       funct_valid
);
    always_comb begin
        alu_ctrl    = 4'b0010;
        funct_valid = 1'b0;
        case (alu_op)
            2'b00: alu_ctrl = 4'b0010;
            2'b01: alu_ctrl = 4'b0110;
            2'b10: begin
                funct_valid = 1'b1;
                case (funct)
                    6'h20:   alu_ctrl = 4'b0010;
                    6'h22:   alu_ctrl = 4'b0110;
                    6'h24:   alu_ctrl = 4'b0000;
                    6'h25:   alu_ctrl = 4'b0001;
                    6'h2A:   alu_ctrl = 4'b0111;
                    default: funct_valid = 1'b0;
                endcase
            end
            default: alu_ctrl = 4'b0010;
        endcase
    end
endmodule

// ---------------------------------------------------------------------------
// mips_alu
//   32-bit ALU; arithmetic wraps mod 2^32, slt is a signed compare.
//   Ports: a, b, alu_ctrl in; result, zero out.
// ---------------------------------------------------------------------------
module mips_alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_ctrl,
    output logic [31:0] result,
    output logic        zero
);
    always_comb begin
        result = 32'd0;
        case (alu_ctrl)
            4'b0010: result = a + b;
            4'b0110: result = a - b;
            4'b0000: result = a & b;
            4'b0001: result = a | b;
            4'b0111: result = {31'd0, ($signed(a) < $signed(b))};
            default: result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);
endmodule

// ---------------------------------------------------------------------------
// mips_regfile
//   32 x 32 register file, two combinational reads, one write per clock.
//   $0 reads as zero and ignores writes.
//   Ports: clk, reset, we, ra1, ra2, wa, wd in; rd1, rd2 out.
// ---------------------------------------------------------------------------
module mips_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                registers[i] <= 32'd0;
            end
        end else if (we && (wa != 5'd0)) begin
            registers[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

// ---------------------------------------------------------------------------
// mips_dmem
//   Word-addressed data memory, combinational read, synchronous write.
//   Only the word-index bits of the byte address are presented, so accesses
//   wrap around at WORDS words.
//   Ports: clk, reset, re, we, index, wd in; rd out.
// ---------------------------------------------------------------------------
module mips_dmem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] index,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);
    logic [31:0] memory [0:WORDS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                memory[i] <= 32'd0;
            end
        end else if (we) begin
            memory[index] <= wd;
        end
    end

    assign rd = re ? memory[index] : 32'd0;
endmodule

// ---------------------------------------------------------------------------
// mips_single_cycle (top)
// ---------------------------------------------------------------------------
module mips_single_cycle #(
    parameter string IMEM_FILE  = "program.hex",
    parameter int    DMEM_WORDS = 256
) (
    input logic clk,
    input logic reset
);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] imem [0:255];

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] instr;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] imm_ext;

    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctrl;
    logic        funct_valid;
    logic        reg_write_eff;

    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] mem_data;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;

    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Fetch: word-indexed, wraps at 256 words.
    assign instr  = imem[pc[9:2]];

    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign imm     = instr[15:0];
    assign target  = instr[25:0];
    assign imm_ext = {{16{imm[15]}}, imm};

    mips_control u_control (
        .opcode     (opcode),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch     (branch),
        .jump       (jump),
        .alu_op     (alu_op)
    );

    mips_alu_control u_alu_control (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_ctrl    (alu_ctrl),
        .funct_valid (funct_valid)
    );

    // An R-type with an unimplemented funct must not write back.
    assign reg_write_eff = reg_write && ((alu_op != 2'b10) || funct_valid);

    assign wb_reg  = reg_dst ? rd : rt;
    assign wb_data = mem_to_reg ? mem_data : alu_result;

    mips_regfile registradores (
        .clk   (clk),
        .reset (reset),
        .we    (reg_write_eff),
        .ra1   (rs),
        .ra2   (rt),
        .wa    (wb_reg),
        .wd    (wb_data),
        .rd1   (rs_data),
        .rd2   (rt_data)
    );

    assign alu_b = alu_src ? imm_ext : rt_data;

    mips_alu u_alu (
        .a        (rs_data),
        .b        (alu_b),
        .alu_ctrl (alu_ctrl),
        .result   (alu_result),
        .zero     (alu_zero)
    );

    mips_dmem #(
        .WORDS (DMEM_WORDS)
    ) data_memory (
        .clk   (clk),
        .reset (reset),
        .re    (mem_read),
        .we    (mem_write),
        .index (alu_result[DAW+1:2]),
        .wd    (rt_data),
        .rd    (mem_data)
    );

    // Next PC: jump beats a taken branch; everything else falls through.
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], target, 2'b00};

    always_comb begin
        pc_next = pc_plus4;
        if (jump) begin
            pc_next = jump_target;
        end else if (branch && alu_zero) begin
            pc_next = branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= 32'd0;
        end else begin
            pc <= pc_next;
        end
    end
endmodule

// File: tb/tb_mips_single_cycle.sv
module tb_mips_single_cycle;
    logic clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    logic [31:0] prog  [0:255];
    logic [31:0] m_regs[0:31];
    logic [31:0] m_mem [0:255];
    logic [31:0] m_pc;

    mips_single_cycle #(
        .IMEM_FILE  (""),
        .DMEM_WORDS (256)
    ) dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] f);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] i);
        return {op, s, t, i};
    endfunction

    // Reference instruction-set model: one instruction per call.
    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++)  m_regs[i] = 32'd0;
        for (int i = 0; i < 256; i++) m_mem[i]  = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, se, npc, ea;
        logic [5:0]  op, fn;
        logic [4:0]  s, t, d;
        ins = prog[m_pc[9:2]];
        op  = ins[31:26];
        s   = ins[25:21];
        t   = ins[20:16];
        d   = ins[15:11];
        fn  = ins[5:0];
        a   = m_regs[s];
        b   = m_regs[t];
        se  = {{16{ins[15]}}, ins[15:0]};
        npc = m_pc + 32'd4;
        ea  = a + se;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: if (d != 0) m_regs[d] = a + b;
                    6'h22: if (d != 0) m_regs[d] = a - b;
                    6'h24: if (d != 0) m_regs[d] = a & b;
                    6'h25: if (d != 0) m_regs[d] = a | b;
                    6'h2A: if (d != 0) m_regs[d] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: ;
                endcase
            end
            6'h08: if (t != 0) m_regs[t] = ea;
            6'h23: if (t != 0) m_regs[t] = m_mem[ea[9:2]];
            6'h2B: m_mem[ea[9:2]] = b;
            6'h04: if (a == b) npc = npc + (se << 2);
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        m_pc = npc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fl [0:5];
        logic [5:0]  bad_ops [0:3];
        logic [4:0]  s, t, d;
        int          k;
        fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24;
        fl[3] = 6'h25; fl[4] = 6'h2A; fl[5] = 6'h3F;
        bad_ops[0] = 6'h01; bad_ops[1] = 6'h0D; bad_ops[2] = 6'h3F; bad_ops[3] = 6'h05;
        s = 5'($urandom_range(0, 7));
        t = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        k = $urandom_range(0, 19);
        if (k <= 7)       return enc_r(s, t, d, fl[$urandom_range(0, 5)]);
        else if (k <= 10) return enc_i(6'h08, s, t, 16'($urandom));
        else if (k <= 12) return enc_i(6'h23, s, t, 16'($urandom));
        else if (k <= 14) return enc_i(6'h2B, s, t, 16'($urandom));
        else if (k <= 16) return enc_i(6'h04, s, t, 16'($urandom_range(0, 20) - 10));
        else if (k == 17) return {6'h02, 26'($urandom)};
        else if (k == 18) return {bad_ops[$urandom_range(0, 3)], 26'($urandom)};
        else              return enc_i(6'h08, s, 5'd0, 16'($urandom));
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_pc"}, dut.pc, m_pc);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_r%0d", tag, i), dut.registradores.registers[i], m_regs[i]);
    endtask

    initial begin
        reset = 1'b1;

        // ---------------- directed program ----------------
        for (int i = 0; i < 256; i++) prog[i] = 32'd0;
        prog[0]  = 32'h20010005;   // addi $1,$0,5
        prog[1]  = 32'h20020007;   // addi $2,$0,7
        prog[2]  = 32'h00221820;   // add  $3,$1,$2
        prog[3]  = 32'h00222022;   // sub  $4,$1,$2
        prog[4]  = 32'h00222824;   // and  $5,$1,$2
        prog[5]  = 32'h00223025;   // or   $6,$1,$2
        prog[6]  = 32'h0022382A;   // slt  $7,$1,$2
        prog[7]  = 32'h0041402A;   // slt  $8,$2,$1
        prog[8]  = 32'h10210002;   // 0x20: beq $1,$1,+2 -> 0x2C
        prog[9]  = 32'h2009DEAD;   // skipped
        prog[10] = 32'h2009BEEF;   // skipped
        prog[11] = 32'h20000009;   // 0x2C: addi $0,$0,9
        prog[12] = 32'hAC030008;   // sw $3,8($0)
        prog[13] = 32'h8C090008;   // lw $9,8($0)
        prog[14] = 32'h10220005;   // 0x38: beq $1,$2,+5 (not taken)
        prog[15] = 32'h08000010;   // 0x3C: j 0x10 -> 0x40
        prog[16] = 32'hFC000000;   // unknown opcode
        prog[17] = 32'h0022483F;   // R-type unknown funct, rd=$9
        prog[18] = 32'hAC03000C;   // 0x48: sw $3,12($0) under reset
        load_prog();

        tick();
        check("reset_pc", dut.pc, 32'd0);
        for (int i = 0; i < 32; i++)
            check($sformatf("reset_r%0d", i), dut.registradores.registers[i], 32'd0);
        for (int i = 0; i < 256; i++)
            check($sformatf("reset_m%0d", i), dut.data_memory.memory[i], 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) tick();
        check("addi_r1", dut.registradores.registers[1], 32'd5);
        check("addi_r2", dut.registradores.registers[2], 32'd7);
        check("add_r3",  dut.registradores.registers[3], 32'd12);
        check("sub_r4",  dut.registradores.registers[4], 32'hFFFFFFFE);
        check("and_r5",  dut.registradores.registers[5], 32'd5);
        check("or_r6",   dut.registradores.registers[6], 32'd7);
        check("slt_r7",  dut.registradores.registers[7], 32'd1);
        check("slt_r8",  dut.registradores.registers[8], 32'd0);
        check("pc_0x20", dut.pc, 32'h20);
        tick();
        check("beq_taken_pc", dut.pc, 32'h2C);
        tick();
        check("r0_write", dut.registradores.registers[0], 32'd0);
        tick();
        check("sw_m2", dut.data_memory.memory[2], 32'd12);
        tick();
        check("lw_r9", dut.registradores.registers[9], 32'd12);
        check("pc_0x38", dut.pc, 32'h38);
        tick();
        check("beq_not_taken_pc", dut.pc, 32'h3C);
        tick();
        check("j_pc", dut.pc, 32'h40);
        tick();
        check("bad_op_pc", dut.pc, 32'h44);
        tick();
        check("bad_funct_r9", dut.registradores.registers[9], 32'd12);
        check("bad_funct_pc", dut.pc, 32'h48);
        reset = 1'b1;
        tick();
        check("midreset_pc", dut.pc, 32'd0);
        check("midreset_m3", dut.data_memory.memory[3], 32'd0);
        check("midreset_m2", dut.data_memory.memory[2], 32'd0);
        check("midreset_r3", dut.registradores.registers[3], 32'd0);
        reset = 1'b0;
        tick();
        check("restart_r1", dut.registradores.registers[1], 32'd5);
        check("restart_pc", dut.pc, 32'h4);

        // ---------------- random program vs reference model ----------------
        for (int i = 0; i < 256; i++) prog[i] = rand_instr();
        reset = 1'b1;
        load_prog();
        tick();
        model_reset();
        compare_all("rnd_reset");
        reset = 1'b0;
        for (int step = 0; step < 400; step++) begin
            if (step == 200) begin
                reset = 1'b1;
                tick();
                model_reset();
                compare_all("rnd_midreset");
                reset = 1'b0;
            end
            tick();
            model_step();
            compare_all($sformatf("rnd%0d", step));
        end
        for (int i = 0; i < 256; i++)
            check($sformatf("rnd_m%0d", i), dut.data_memory.memory[i], m_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
